// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite command master: turns single-beat local read/write commands into
// AXI4-Lite transactions, adds a fixed base address and returns the captured
// response with a saturating error counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a command (cmd_ready high outside reset)
// WR_REQ  | AW and W offered; each valid drops after its own handshake
// WR_RESP | BREADY high, waiting for the write response
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_DATA | RREADY high, waiting for read data
// RESP    | rsp_valid high, holding response fields until rsp_ready
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [15:0]                       err_count,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                            aw_done_q;
    logic                            w_done_q;
    logic                            cmd_accept;
    logic                            resp_capture;
    logic [1:0]                      resp_in;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    assign cmd_accept   = cmd_valid && cmd_ready;
    assign resp_capture = ((state_q == WR_RESP) && M_AXI_BVALID) ||
                          ((state_q == RD_DATA) && M_AXI_RVALID);
    assign resp_in      = (state_q == RD_DATA) ? M_AXI_RRESP : M_AXI_BRESP;

    // State register.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded handshake outputs; AXI inputs only steer
    // the next state, never an AXI output directly.
    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so no command is seen as accepted while
                // the block is being held in reset.
                cmd_ready = !M_AXI_ARESET;
                if (cmd_valid && !M_AXI_ARESET) begin
                    state_d = cmd_rnw ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    state_d = RESP;
                end
            end
            RD_REQ: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, per-channel write completion flags, response capture
    // and the saturating error counter.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            err_count <= 16'h0000;
        end else begin
            if (cmd_accept) begin
                addr_q    <= cmd_addr + BASE_ADDR;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == WR_REQ) begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    aw_done_q <= 1'b1;
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    w_done_q <= 1'b1;
                end
            end
            if (resp_capture) begin
                rsp_resp  <= resp_in;
                rsp_rdata <= (state_q == RD_DATA) ? M_AXI_RDATA : '0;
                if ((resp_in != 2'b00) && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule
